// File: rtl/memwb_stage_pkg.sv
// Shared types for the M->W stage: data-bus payloads, hold FSM states, error bit positions.
package memwb_stage_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned ERR_W  = 12;
    localparam int unsigned STRB_W = DATA_W / 8;

    localparam int unsigned ERR_ADEL = 5;
    localparam int unsigned ERR_ADES = 4;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] addr;
        logic [2:0]        size;
        logic [STRB_W-1:0] strobe;
        logic [DATA_W-1:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic              addr_ok;
        logic              data_ok;
        logic [DATA_W-1:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ADDR = 2'd1,
        WAIT_DATA = 2'd2,
        DRAIN     = 2'd3
    } memwb_state_t;

endpackage

// File: rtl/memwb_stage_dbus_hold.sv
// Data-bus handshake owner: keeps a request stable until accepted, waits for its data,
// drains accesses squashed by a flush, and holds the last read data for the frozen M stage.
module memwb_stage_dbus_hold
    import memwb_stage_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       flush,
    input  dbus_req_t  req_m,
    input  dbus_resp_t dresp,
    output dbus_req_t  dreq_c,
    output dbus_resp_t resp_c,
    output logic       stall_c,
    output logic       squash_c
);

    memwb_state_t      state;
    dbus_req_t         req_q;
    logic              flushed_q;
    logic [DATA_W-1:0] hold_q;
    logic              complete_c;

    // Bus-facing decode: request shown to the bus, completion, freeze and squash of the access
    always_comb begin
        dreq_c       = req_q;
        dreq_c.valid = 1'b0;
        complete_c   = 1'b0;
        stall_c      = 1'b0;
        squash_c     = 1'b0;
        unique case (state)
            IDLE: begin
                dreq_c     = req_m;
                complete_c = req_m.valid & dresp.addr_ok & dresp.data_ok;
                stall_c    = req_m.valid & ~complete_c;
            end
            WAIT_ADDR: begin
                dreq_c.valid = 1'b1;
                complete_c   = dresp.addr_ok & dresp.data_ok;
                stall_c      = ~complete_c;
                squash_c     = flushed_q;
            end
            WAIT_DATA: begin
                complete_c = dresp.data_ok;
                stall_c    = ~complete_c;
            end
            DRAIN: begin
                stall_c = 1'b1;
            end
        endcase
        resp_c      = dresp;
        resp_c.data = complete_c ? dresp.data : hold_q;
    end

    // Handshake FSM, request latch, pending-flush flag and read-data hold register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            req_q     <= '0;
            flushed_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            if (complete_c) begin
                hold_q <= dresp.data;
            end
            unique case (state)
                IDLE: begin
                    if (req_m.valid) begin
                        req_q <= req_m;
                        if (dresp.addr_ok && !dresp.data_ok) begin
                            state <= flush ? DRAIN : WAIT_DATA;
                        end else if (!dresp.addr_ok && !flush) begin
                            state <= WAIT_ADDR;
                        end
                    end
                end
                WAIT_ADDR: begin
                    flushed_q <= flushed_q | flush;
                    if (dresp.addr_ok) begin
                        flushed_q <= 1'b0;
                        if (dresp.data_ok) begin
                            state <= IDLE;
                        end else if (flushed_q || flush) begin
                            state <= DRAIN;
                        end else begin
                            state <= WAIT_DATA;
                        end
                    end
                end
                WAIT_DATA: begin
                    if (dresp.data_ok) begin
                        state <= IDLE;
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (dresp.data_ok) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/memwb_stage.sv
// M->W pipeline stage: drives the data-bus handshake and registers M results into W.
module memwb_stage
    import memwb_stage_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              regwrite_m,
    input  logic              memtoreg_m,
    input  logic [REG_W-1:0]  rd_m,
    input  logic [DATA_W-1:0] ALUout_m,
    input  logic [DATA_W-1:0] ReadData_m,
    input  logic [ERR_W-1:0]  error_m,
    input  logic [DATA_W-1:0] BadVaddr_m,
    input  dbus_req_t         req_m,
    output dbus_req_t         dreq,
    input  dbus_resp_t        dresp,
    output dbus_resp_t        resp_m,
    output logic              stall_m,
    output logic              regwrite_w,
    output logic              memtoreg_w,
    output logic [REG_W-1:0]  rd_w,
    output logic [DATA_W-1:0] ALUout_w,
    output logic [DATA_W-1:0] ReadData_w,
    output logic [DATA_W-1:0] BadVaddr_w,
    output logic [ERR_W-1:0]  error_w
);

    logic stall_c;
    logic squash_c;
    logic load_w;

    memwb_stage_dbus_hold u_hold (
        .clk      (clk),
        .resetn   (resetn),
        .flush    (flush),
        .req_m    (req_m),
        .dresp    (dresp),
        .dreq_c   (dreq),
        .resp_c   (resp_m),
        .stall_c  (stall_c),
        .squash_c (squash_c)
    );

    assign stall_m = stall_c;
    // A squashed access can complete without stalling; it still must not reach W.
    assign load_w  = ~stall_c & ~flush & ~squash_c;

    // W register: load M results when M advances, otherwise insert a bubble keeping data fields
    always_ff @(posedge clk) begin
        if (!resetn) begin
            regwrite_w <= 1'b0;
            memtoreg_w <= 1'b0;
            rd_w       <= '0;
            ALUout_w   <= '0;
            ReadData_w <= '0;
            BadVaddr_w <= '0;
            error_w    <= '0;
        end else if (load_w) begin
            regwrite_w <= regwrite_m;
            memtoreg_w <= memtoreg_m;
            rd_w       <= rd_m;
            ALUout_w   <= ALUout_m;
            ReadData_w <= ReadData_m;
            BadVaddr_w <= BadVaddr_m;
            error_w    <= error_m;
        end else begin
            regwrite_w <= 1'b0;
            memtoreg_w <= 1'b0;
            rd_w       <= '0;
            error_w    <= '0;
        end
    end

endmodule
